dual_issue_queue: RTL

DUAL_ISSUE_QUEUE -- requirements
Module: dual_issue_queue

---
 rtl/dual_issue_pkg.sv | 62 ++++++
 rtl/pair_check.sv | 24 ++
 rtl/dual_issue_queue.sv | 96 +++++++++
 3 files changed

// File: rtl/dual_issue_pkg.sv
// Shared opcode constants and register-field decode for the dual-issue queue.
// Decode covers only the opcode subset the pairing rules care about.
package dual_issue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       has_dest;
        logic [4:0] dest;
        logic       has_rs;
        logic [4:0] rs;
        logic       has_rt;
        logic [4:0] rt;
    } regs_t;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic regs_t decode_regs(input logic [31:0] instr);
        regs_t      r;
        logic [5:0] op;
        op = instr[31:26];
        r  = '0;
        r.rs = instr[25:21];
        r.rt = instr[20:16];
        case (op)
            OP_RTYPE: begin
                r.has_dest = 1'b1;
                r.dest     = instr[15:11];
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                r.has_dest = 1'b1;
                r.dest     = instr[20:16];
            end
            default: ;
        endcase
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
                r.has_rs = 1'b1;
                r.has_rt = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW: r.has_rs = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pair_check.sv
// Combinational hazard check: can younger instruction B issue alongside older A.
// Register $0 is never a hazard since writes to it are discarded.
module pair_check
    import dual_issue_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_can_pair
);

    regs_t w_ra, w_rb;
    logic  w_a_writes, w_raw, w_waw;

    assign w_ra = decode_regs(i_a);
    assign w_rb = decode_regs(i_b);

    assign w_a_writes = w_ra.has_dest && (w_ra.dest != 5'd0);
    assign w_raw = w_a_writes && ((w_rb.has_rs && (w_rb.rs == w_ra.dest)) ||
                                  (w_rb.has_rt && (w_rb.rt == w_ra.dest)));
    assign w_waw = w_a_writes && w_rb.has_dest && (w_rb.dest == w_ra.dest);

    assign o_can_pair = !is_branch(i_a[31:26]) && !w_raw && !w_waw;

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction queue feeding a two-lane EX stage; issues head and
// head+1 together when pair_check allows, otherwise one (or none) per cycle.
module dual_issue_queue
    import dual_issue_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_pair,
    input  logic [31:0]              in_instr0,
    input  logic [31:0]              in_instr1,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     ex_stall,
    output logic [31:0]              instr1_out,
    output logic [31:0]              instr2_out,
    output logic [31:0]              pair_count,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_out1, r_out2, r_pairs;

    logic [31:0]   w_a, w_b;
    logic          w_can_pair, w_push, w_issue;
    logic [1:0]    w_push_n, w_pop_n;

    assign w_a = r_mem[r_head];
    assign w_b = r_mem[r_head + AW'(1)];

    pair_check u_pair_check (
        .i_a        (w_a),
        .i_b        (w_b),
        .o_can_pair (w_can_pair)
    );

    // Two free slots are always required so a pair offer never needs splitting.
    assign in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push   = in_valid && in_ready;
    assign w_push_n = w_push ? (in_pair ? 2'd2 : 2'd1) : 2'd0;
    assign w_issue  = !ex_stall && !flush;

    always_comb begin
        w_pop_n = 2'd0;
        if (w_issue) begin
            if (r_count >= CW'(2))
                w_pop_n = w_can_pair ? 2'd2 : 2'd1;
            else if (r_count == CW'(1))
                w_pop_n = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out1  <= NOP;
            r_out2  <= NOP;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= in_instr0;
                if (in_pair)
                    r_mem[r_tail + AW'(1)] <= in_instr1;
                r_tail <= r_tail + AW'(w_push_n);
            end
            if (w_issue) begin
                r_out1 <= (w_pop_n != 2'd0) ? w_a : NOP;
                r_out2 <= (w_pop_n == 2'd2) ? w_b : NOP;
                r_head <= r_head + AW'(w_pop_n);
            end
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pairs <= '0;
        else if (w_pop_n == 2'd2)
            r_pairs <= r_pairs + 32'd1;
    end

    assign instr1_out = r_out1;
    assign instr2_out = r_out2;
    assign pair_count = r_pairs;
    assign occupancy  = r_count;

endmodule
